// File: rtl/rho_rotate_engine.sv
`default_nettype none
// ============================================================================
//  Module   : rho_rotate_engine
//  Brief    : Keccak-f[1600] rho step on a slice-organised state. Rotates
//             LANES_PER_CYCLE lanes per cycle in place in a work register and
//             presents the rotated state with a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module rho_rotate_engine #(
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1599:0] data_in,
    output logic          busy,
    output logic          done,
    output logic [1599:0] data_out
);

    // Rho offsets indexed by lane L = 5y+x.
    localparam int c_rho [25] = '{ 0,  1, 62, 28, 27,
                                  36, 44,  6, 55, 20,
                                   3, 10, 43, 25, 39,
                                  41, 45, 15, 21,  8,
                                  18,  2, 61, 56, 14};

    localparam logic [5:0] c_lpc     = 6'(LANES_PER_CYCLE);
    localparam logic [5:0] c_last_lc = 6'(25 - LANES_PER_CYCLE);

    // Only lane groupings that divide 25 evenly are supported.
    if ((LANES_PER_CYCLE != 1) && (LANES_PER_CYCLE != 5) && (LANES_PER_CYCLE != 25)) begin : g_bad_lpc
        $fatal(1, "rho_rotate_engine: LANES_PER_CYCLE must be 1, 5 or 25");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         r_state;
    logic [5:0]     r_lc;
    logic [1599:0]  r_work;
    logic [1599:0]  r_data_out;
    logic           r_busy;
    logic           r_done;

    logic [24:0]    w_sel;
    logic [1599:0]  w_work_nxt;

    // Per-lane rotation is pure wiring: each lane is selected when the lane
    // counter points at the first lane of its group, and then every bit z of
    // that lane takes bit (z - r) mod 64 of the same lane.
    for (genvar gl = 0; gl < 25; gl++) begin : g_lane
        assign w_sel[gl] = (r_lc == 6'((gl / LANES_PER_CYCLE) * LANES_PER_CYCLE));
        for (genvar gz = 0; gz < 64; gz++) begin : g_bit
            assign w_work_nxt[25*gz + 24 - gl] =
                w_sel[gl] ? r_work[25*((gz + 64 - c_rho[gl]) % 64) + 24 - gl]
                          : r_work[25*gz + 24 - gl];
        end
    end

    // Control FSM, work register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lc       <= 6'd0;
            r_work     <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                // DONE samples start exactly like IDLE so operations can run
                // back to back.
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= data_in;
                        r_lc    <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ROTATE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ROTATE: begin
                    r_work <= w_work_nxt;
                    r_lc   <= r_lc + c_lpc;
                    if (r_lc == c_last_lc) begin
                        r_data_out <= w_work_nxt;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule
`default_nettype wire
